// File: rtl/axi_rdata_return_arb.sv
// AXI read-return arbiter: N slave R channels to one master, burst-locked grant, registered R output.
// Optional build macro RDATA_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module axi_rdata_return_arb #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_WIDTH = 2,
  localparam int unsigned SEL_W     = $clog2(NUM_SLAVES)
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_RDATA,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] S_RRESP,
  input  logic [NUM_SLAVES-1:0]            S_RLAST,
  input  logic [NUM_SLAVES-1:0]            S_RVALID,
  output logic [NUM_SLAVES-1:0]            S_RREADY,
  output logic [DATA_WIDTH-1:0]            M_RDATA,
  output logic [RESP_WIDTH-1:0]            M_RRESP,
  output logic                             M_RLAST,
  output logic                             M_RVALID,
  input  logic                             M_RREADY,
  output logic [SEL_W-1:0]                 GRANT_SEL,
  output logic                             BUSY
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic                    load_en;
  logic                    any_valid;
  logic [SEL_W-1:0]        winner;
  logic [SEL_W-1:0]        sel;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic [RESP_WIDTH-1:0]   beat_resp;
  logic                    beat_last;

  assign load_en = !M_RVALID || M_RREADY;

`ifdef RDATA_ARB_FIXED_PRIO_EN
  // Lowest-index requester wins; descending scan leaves the lowest assignment.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (S_RVALID[i]) begin
        winner    = SEL_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] rr_ptr;
  logic             hi_found;
  logic [SEL_W-1:0] hi_win;
  logic [SEL_W-1:0] lo_win;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] g);
    return (g == SEL_W'(NUM_SLAVES - 1)) ? '0 : g + 1'b1;
  endfunction

  // Round-robin: lowest requester at/above the pointer, else lowest below it.
  always_comb begin
    hi_found  = 1'b0;
    hi_win    = '0;
    lo_win    = '0;
    any_valid = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (S_RVALID[i]) begin
        any_valid = 1'b1;
        if (SEL_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_win   = SEL_W'(i);
        end else begin
          lo_win   = SEL_W'(i);
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end
`endif

  assign sel = (state == IDLE) ? winner : GRANT_SEL;

  // Ready goes only to the granted slave, and only when the output register can load.
  always_comb begin
    S_RREADY = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (state == BURST)
        S_RREADY[i] = ARESETN && load_en && (GRANT_SEL == SEL_W'(i));
      else
        S_RREADY[i] = ARESETN && load_en && any_valid && (winner == SEL_W'(i));
    end
  end

  assign accept = |(S_RVALID & S_RREADY);

  always_comb begin
    beat_data = '0;
    beat_resp = '0;
    beat_last = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel == SEL_W'(i)) begin
        beat_data = S_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
        beat_resp = S_RRESP[i*RESP_WIDTH +: RESP_WIDTH];
        beat_last = S_RLAST[i];
      end
    end
  end

  // Output register and burst-lock FSM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      GRANT_SEL <= '0;
      M_RVALID  <= 1'b0;
      M_RDATA   <= '0;
      M_RRESP   <= '0;
      M_RLAST   <= 1'b0;
`ifndef RDATA_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      if (load_en) begin
        if (accept) begin
          M_RVALID <= 1'b1;
          M_RDATA  <= beat_data;
          M_RRESP  <= beat_resp;
          M_RLAST  <= beat_last;
        end else begin
          M_RVALID <= 1'b0;
        end
      end
      if (accept) begin
        unique case (state)
          IDLE: begin
            GRANT_SEL <= winner;
            if (beat_last) begin
`ifndef RDATA_ARB_FIXED_PRIO_EN
              rr_ptr <= wrap_inc(winner);
`endif
            end else begin
              state <= BURST;
              BUSY  <= 1'b1;
            end
          end
          BURST: begin
            if (beat_last) begin
              state <= IDLE;
              BUSY  <= 1'b0;
`ifndef RDATA_ARB_FIXED_PRIO_EN
              rr_ptr <= wrap_inc(GRANT_SEL);
`endif
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_rdata_return_arb.sv
// Directed self-checking bench for axi_rdata_return_arb (default round-robin build).
module tb_axi_rdata_return_arb;

  logic         ACLK;
  logic         ARESETN;

  logic [127:0] s_rdata;
  logic [7:0]   s_rresp;
  logic [3:0]   s_rlast;
  logic [3:0]   s_rvalid;
  logic [3:0]   s_rready;
  logic [31:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         m_rvalid;
  logic         m_rready;
  logic [1:0]   grant_sel;
  logic         busy;

  logic [191:0] t_rdata;
  logic [5:0]   t_rresp;
  logic [2:0]   t_rlast;
  logic [2:0]   t_rvalid;
  logic [2:0]   t_rready;
  logic [63:0]  t_m_rdata;
  logic [1:0]   t_m_rresp;
  logic         t_m_rlast;
  logic         t_m_rvalid;
  logic         t_m_rready;
  logic [1:0]   t_grant;
  logic         t_busy;

  int n_assert = 0;
  int n_fail   = 0;

  axi_rdata_return_arb #(.NUM_SLAVES(4), .DATA_WIDTH(32), .RESP_WIDTH(2)) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RLAST(s_rlast), .S_RVALID(s_rvalid),
    .S_RREADY(s_rready),
    .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast), .M_RVALID(m_rvalid),
    .M_RREADY(m_rready), .GRANT_SEL(grant_sel), .BUSY(busy)
  );

  axi_rdata_return_arb #(.NUM_SLAVES(3), .DATA_WIDTH(64), .RESP_WIDTH(2)) u_dut3 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_RDATA(t_rdata), .S_RRESP(t_rresp), .S_RLAST(t_rlast), .S_RVALID(t_rvalid),
    .S_RREADY(t_rready),
    .M_RDATA(t_m_rdata), .M_RRESP(t_m_rresp), .M_RLAST(t_m_rlast), .M_RVALID(t_m_rvalid),
    .M_RREADY(t_m_rready), .GRANT_SEL(t_grant), .BUSY(t_busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESETN    = 1'b0;
    s_rdata    = '0;
    s_rresp    = '0;
    s_rlast    = '0;
    s_rvalid   = '0;
    m_rready   = 1'b1;
    t_rdata    = '0;
    t_rresp    = '0;
    t_rlast    = '0;
    t_rvalid   = '0;
    t_m_rready = 1'b1;
    tick;
    tick;
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_grant", 64'(grant_sel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rready", 64'(s_rready), 64'd0);
    ARESETN = 1'b1;
    tick;

    // T2: 4-beat burst from S1
    s_rvalid          = 4'b0010;
    s_rdata[32 +: 32] = 32'hA0;
    s_rresp[2 +: 2]   = 2'b01;
    s_rlast           = 4'b0000;
    #1 chk("t2_rdy", 64'(s_rready), 64'b0010);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t2_valid", 64'(m_rvalid), 64'd1);
      chk("t2_data", 64'(m_rdata), 64'(32'hA0 + k));
      chk("t2_last", 64'(m_rlast), 64'(k == 3));
      chk("t2_busy", 64'(busy), 64'(k != 3));
      if (k < 3) begin
        s_rdata[32 +: 32] = 32'(32'hA1 + k);
        s_rlast[1]        = (k == 2);
      end else begin
        s_rvalid = 4'b0000;
        s_rlast  = 4'b0000;
      end
    end
    chk("t2_grant", 64'(grant_sel), 64'd1);
    chk("t2_resp", 64'(m_rresp), 64'd1);
    tick;
    chk("t2_drain", 64'(m_rvalid), 64'd0);

    // T1: reset asserted mid-burst (S3 wins from pointer 2)
    s_rvalid          = 4'b1000;
    s_rdata[96 +: 32] = 32'h55;
    tick;
    chk("t1_pre_valid", 64'(m_rvalid), 64'd1);
    chk("t1_pre_grant", 64'(grant_sel), 64'd3);
    chk("t1_pre_busy", 64'(busy), 64'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("t1_valid", 64'(m_rvalid), 64'd0);
    chk("t1_rready", 64'(s_rready), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_grant", 64'(grant_sel), 64'd0);
    chk("t1_data", 64'(m_rdata), 64'd0);
    s_rvalid = 4'b0000;
    tick;
    ARESETN = 1'b1;
    tick;

    // T3: S0 and S2 contend with 2-beat bursts, pointer 0
    s_rvalid           = 4'b0101;
    s_rdata[0 +: 32]   = 32'hB0;
    s_rdata[64 +: 32]  = 32'hC0;
    s_rlast            = 4'b0000;
    #1 chk("t3_rdy_s0", 64'(s_rready), 64'b0001);
    tick;
    chk("t3_b0", 64'(m_rdata), 64'hB0);
    chk("t3_g0", 64'(grant_sel), 64'd0);
    s_rdata[0 +: 32] = 32'hB1;
    s_rlast[0]       = 1'b1;
    #1 chk("t3_no_ilv", 64'(s_rready), 64'b0001);
    tick;
    chk("t3_b1", 64'(m_rdata), 64'hB1);
    chk("t3_b1_last", 64'(m_rlast), 64'd1);
    chk("t3_b1_busy", 64'(busy), 64'd0);
    s_rvalid = 4'b0100;
    s_rlast  = 4'b0000;
    #1 chk("t3_rdy_s2", 64'(s_rready), 64'b0100);
    tick;
    chk("t3_c0", 64'(m_rdata), 64'hC0);
    chk("t3_g2", 64'(grant_sel), 64'd2);
    s_rdata[64 +: 32] = 32'hC1;
    s_rlast[2]        = 1'b1;
    tick;
    chk("t3_c1", 64'(m_rdata), 64'hC1);
    chk("t3_c1_last", 64'(m_rlast), 64'd1);
    s_rvalid = 4'b1001;
    s_rlast  = 4'b0000;
    #1 chk("t3_ptr3", 64'(s_rready), 64'b1000);
    s_rvalid = 4'b0000;
    tick;
    chk("t3_drain", 64'(m_rvalid), 64'd0);

    // T4: backpressure on beat 2 of 3 from S1
    s_rvalid          = 4'b0010;
    s_rdata[32 +: 32] = 32'hD0;
    tick;
    chk("t4_d0", 64'(m_rdata), 64'hD0);
    s_rdata[32 +: 32] = 32'hD1;
    tick;
    chk("t4_d1", 64'(m_rdata), 64'hD1);
    m_rready          = 1'b0;
    s_rdata[32 +: 32] = 32'hD2;
    s_rlast[1]        = 1'b1;
    #1 chk("t4_rdy_off", 64'(s_rready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("t4_hold_data", 64'(m_rdata), 64'hD1);
      chk("t4_hold_valid", 64'(m_rvalid), 64'd1);
      chk("t4_hold_last", 64'(m_rlast), 64'd0);
      chk("t4_hold_rdy", 64'(s_rready), 64'd0);
    end
    m_rready = 1'b1;
    #1 chk("t4_rdy_on", 64'(s_rready), 64'b0010);
    tick;
    chk("t4_d2", 64'(m_rdata), 64'hD2);
    chk("t4_d2_last", 64'(m_rlast), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    s_rvalid = 4'b0000;
    s_rlast  = 4'b0000;
    tick;
    chk("t4_no_dup", 64'(m_rvalid), 64'd0);

    // T5: fairness with continuous single-beat bursts from every slave
    ARESETN = 1'b0;
    tick;
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = 32'(32'hE0 + i);
    s_rvalid = 4'b1111;
    s_rlast  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t5_grant", 64'(grant_sel), 64'(k % 4));
      chk("t5_data", 64'(m_rdata), 64'(32'hE0 + (k % 4)));
      chk("t5_busy", 64'(busy), 64'd0);
    end
    s_rvalid = 4'b0000;
    s_rlast  = 4'b0000;
    tick;

    // T6: 3 slaves x 64 bits, wrap from S2 to S0, upper slices intact
    t_rvalid           = 3'b100;
    t_rlast            = 3'b100;
    t_rdata[128 +: 64] = 64'h1122334455667788;
    t_rresp[4 +: 2]    = 2'b10;
    #1 chk("t6_rdy_s2", 64'(t_rready), 64'b100);
    tick;
    chk("t6_d2", t_m_rdata, 64'h1122334455667788);
    chk("t6_resp2", 64'(t_m_rresp), 64'd2);
    chk("t6_g2", 64'(t_grant), 64'd2);
    t_rvalid          = 3'b111;
    t_rlast           = 3'b111;
    t_rdata[0 +: 64]  = 64'h0123456789ABCDEF;
    t_rdata[64 +: 64] = 64'hDEADBEEFCAFEF00D;
    #1 chk("t6_wrap_rdy", 64'(t_rready), 64'b001);
    tick;
    chk("t6_g0", 64'(t_grant), 64'd0);
    chk("t6_d0", t_m_rdata, 64'h0123456789ABCDEF);
    tick;
    chk("t6_g1", 64'(t_grant), 64'd1);
    chk("t6_d1", t_m_rdata, 64'hDEADBEEFCAFEF00D);
    t_rvalid = 3'b000;
    t_rlast  = 3'b000;
    tick;
    chk("t6_drain", 64'(t_m_rvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
